matrix_column_scanner: RTL and testbench
========================================

# matrix_column_scanner

Time-multiplexed driver for the 5×7 LED matrix. Consumes the five 7-bit column patterns produced by the matrix image selector and scans them onto the physical matrix one column at a time. Each column slot starts with a blanking interval to suppress ghosting. The frame is double-buffered: input patterns are captured once per frame, so an image change never tears mid-scan.

## Interface
Parameters:
- `CLOCK_DIVIDER`, default 50000: clock cycles per column slot (≥2). Frame period = 5×CLOCK_DIVIDER cycles.
- `BLANK_CYCLES`, default 16: blanking cycles at the start of each slot (0 ≤ BLANK_CYCLES < CLOCK_DIVIDER).
- `ROW_ACTIVE_LOW`, default 0: 1 inverts the `rows` output.
- `COLUMN_ACTIVE_LOW`, default 1: 1 inverts the `columns` output.

Ports:
- `clock` in 1: single system clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `enable` in 1: scan enable; low blanks the matrix.
- `column_4` … `column_0` in 7 each: pixel patterns; bit=1 means LED on.
- `rows` out 7: row drive for the selected column, polarity per `ROW_ACTIVE_LOW`.
- `columns` out 5: one-hot column select, bit i = column i, polarity per `COLUMN_ACTIVE_LOW`.
- `column_index` out 3: column currently scanned, range 4..0.
- `frame_start` out 1: one-cycle pulse when a new frame is latched.

## Operation
- States:
  - IDLE: enable low, matrix dark.
  - BLANK: column selected, all outputs inactive.
  - DRIVE: column lit.
- Slot counter `tick` counts 0..CLOCK_DIVIDER−1.
  - Width is $clog2(CLOCK_DIVIDER).
  - Wraps to 0 at the end of each slot.
- Scan order is column 4, 3, 2, 1, 0, then wraps back to 4.
- Shadow registers `frame[4:0]` hold 7 bits each.
  - All five are loaded from `column_4..column_0` on the edge that starts a column-4 slot, i.e. on the IDLE→scan transition or the wrap 0→4.
  - `frame_start` is asserted for exactly the cycle following that load.
- BLANK: `tick` < BLANK_CYCLES. Outputs are raw rows=0 and raw columns=0.
- DRIVE: `tick` ≥ BLANK_CYCLES.
  - Raw columns = one-hot(`column_index`).
  - Raw rows = `frame[column_index]`.
- If BLANK_CYCLES=0, BLANK is never entered and each slot is DRIVE only.
- Every output is registered. Physical value = raw XOR its polarity parameter (replicated to the output width).
- Reset values, and the values held throughout IDLE:
  - Raw rows=0, raw columns=0 (physical: rows 7'h00 and columns 5'h1F with default parameters).
  - `column_index`=4, `frame_start`=0, `tick`=0, `frame`=0, state IDLE.
- `enable` low in any state: on the next edge go to IDLE. Outputs are inactive, `tick`=0, `column_index`=4. The shadow frame is retained but unused.
- `enable` high in IDLE: on the next edge load the shadow frame, enter BLANK (or DRIVE if BLANK_CYCLES=0) with `tick`=0 and `column_index`=4, and pulse `frame_start`.
- Input pattern changes mid-frame have no visible effect until the next column-4 load.
- `reset_n` asserted at any point forces all reset values immediately, with no clock edge needed. On deassertion the block resumes from IDLE.

## Timing
- Enable latency: `enable` sampled high at edge k. From edge k the outputs are blank for BLANK_CYCLES cycles. Column 4 is lit from edge k+BLANK_CYCLES.
- Slot boundary:
  - At the edge where `tick`=CLOCK_DIVIDER−1, `tick`←0 and `column_index` decrements.
  - At column 0, `column_index` wraps to 4 and the frame reloads.
  - Columns are never lit on two consecutive cycles with different indices unless BLANK_CYCLES=0.
- `frame_start` period is 5×CLOCK_DIVIDER cycles while enabled.
- Disable latency: exactly one edge from `enable` low to all outputs inactive.

## Test plan
- Reset: hold `reset_n`=0 with `enable`=1 and the clock toggling, using default polarities. Required: rows=7'h00, columns=5'h1F, `column_index`=4, `frame_start`=0. Then assert `reset_n` low mid-DRIVE without a clock edge. Required: the same values appear immediately.
- Basic scan with CLOCK_DIVIDER=8, BLANK_CYCLES=2, and column_4..0 = 7'b1111011, 7'b1111101, 7'b0000000, 7'b1111101, 7'b1111011.
  - Raise `enable`. Required: 2 cycles with columns=5'h1F, then 6 cycles with columns=5'b01111 and rows=7'b1111011.
  - Then column 3 (columns=5'b10111, rows=7'b1111101), and so on through column 0.
  - `frame_start` pulses every 40 cycles.
- Tear-free update: while column 2 is scanning, change column_4..0 to the error pattern (7'b1100011, 7'b1011001, 7'b1010101, 7'b1001101, 7'b1100011). Required: columns 1 and 0 still show the old patterns. Column 4 shows 7'b1100011 only after the next `frame_start`.
- Enable drop: deassert `enable` at DRIVE `tick`=5 of column 3. Required: on the next edge, columns=5'h1F, rows=0, `column_index`=4. Re-enable: the block restarts with the column-4 blank phase and a `frame_start` pulse.
- No blanking with BLANK_CYCLES=0 and CLOCK_DIVIDER=4. Required: column 4 is lit on the first enabled cycle, and the columns change directly 5'b01111→5'b10111 with no blank cycle. Wrap 0→4 occurs every 20 cycles.
- Polarity with ROW_ACTIVE_LOW=1 and COLUMN_ACTIVE_LOW=0. Required: idle rows=7'h7F and columns=5'h00. Column 4 active gives columns=5'b10000 and rows=~column_4.

Source files
------------

// File: rtl/matrix_column_scanner.sv
// rtl/matrix_column_scanner.sv - double-buffered 5x7 LED matrix column scanner with per-slot blanking
module matrix_column_scanner #(
    parameter int CLOCK_DIVIDER     = 50000,  // cycles per column slot
    parameter int BLANK_CYCLES      = 16,     // dark cycles at the start of each slot
    parameter bit ROW_ACTIVE_LOW    = 1'b0,   // invert rows
    parameter bit COLUMN_ACTIVE_LOW = 1'b1    // invert columns
) (
    input  logic       clock,         // system clock, rising edge
    input  logic       reset_n,       // asynchronous active-low reset
    input  logic       enable,        // scan enable, low blanks the matrix
    input  logic [6:0] column_4,      // pixel pattern for column 4, 1 = LED on
    input  logic [6:0] column_3,
    input  logic [6:0] column_2,
    input  logic [6:0] column_1,
    input  logic [6:0] column_0,
    output logic [6:0] rows,          // row drive for the scanned column
    output logic [4:0] columns,       // one-hot column select
    output logic [2:0] column_index,  // column being scanned, 4..0
    output logic       frame_start    // one-cycle pulse after a frame load
);

    localparam int TICK_W = (CLOCK_DIVIDER > 1) ? $clog2(CLOCK_DIVIDER) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLOCK_DIVIDER - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BLANK = 2'd1;
    localparam logic [1:0] DRIVE = 2'd2;

    localparam logic [2:0] COL_FIRST = 3'd4;
    localparam logic [6:0] ROW_POL   = {7{ROW_ACTIVE_LOW}};
    localparam logic [4:0] COL_POL   = {5{COLUMN_ACTIVE_LOW}};

    logic [1:0]        state;
    logic [TICK_W-1:0] tick;
    logic [4:0][6:0]   frame;

    logic [1:0]        state_n;
    logic [TICK_W-1:0] tick_n;
    logic [2:0]        index_n;
    logic [4:0][6:0]   frame_n;
    logic              load;
    logic              blank_n;
    logic              lit_n;
    logic [6:0]        raw_rows_n;
    logic [4:0]        raw_cols_n;

    function automatic logic [6:0] pick(input logic [4:0][6:0] f, input logic [2:0] i);
        case (i)
            3'd0:    return f[0];
            3'd1:    return f[1];
            3'd2:    return f[2];
            3'd3:    return f[3];
            3'd4:    return f[4];
            default: return 7'h00;
        endcase
    endfunction

    // Slot position: tick and column index for the coming cycle, plus the
    // shadow-frame load that happens whenever a column-4 slot begins.
    always_comb begin
        tick_n  = tick;
        index_n = column_index;
        load    = 1'b0;
        if (!enable) begin
            tick_n  = '0;
            index_n = COL_FIRST;
        end else if (state == IDLE) begin
            tick_n  = '0;
            index_n = COL_FIRST;
            load    = 1'b1;
        end else if (tick == TICK_LAST) begin
            tick_n = '0;
            if (column_index == 3'd0) begin
                index_n = COL_FIRST;
                load    = 1'b1;
            end else begin
                index_n = column_index - 3'd1;
            end
        end else begin
            tick_n = tick + TICK_W'(1);
        end
    end

    always_comb begin
        frame_n = frame;
        if (load) begin
            frame_n = {column_4, column_3, column_2, column_1, column_0};
        end
    end

    generate
        if (BLANK_CYCLES > 0) begin : g_blank
            localparam logic [TICK_W-1:0] TICK_BLANK = TICK_W'(BLANK_CYCLES);
            assign blank_n = (tick_n < TICK_BLANK);
        end else begin : g_no_blank
            assign blank_n = 1'b0;
        end
    endgenerate

    // Outputs are computed from the next-cycle slot position so that the
    // registered pins line up with the state they describe.
    always_comb begin
        state_n    = IDLE;
        lit_n      = 1'b0;
        raw_rows_n = 7'h00;
        raw_cols_n = 5'h00;
        if (enable) begin
            state_n = blank_n ? BLANK : DRIVE;
            lit_n   = !blank_n;
        end
        if (lit_n) begin
            raw_cols_n = 5'b00001 << index_n;
            raw_rows_n = pick(frame_n, index_n);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            tick         <= '0;
            column_index <= COL_FIRST;
            frame        <= '0;
            rows         <= ROW_POL;
            columns      <= COL_POL;
            frame_start  <= 1'b0;
        end else begin
            state        <= state_n;
            tick         <= tick_n;
            column_index <= index_n;
            frame        <= frame_n;
            rows         <= raw_rows_n ^ ROW_POL;
            columns      <= raw_cols_n ^ COL_POL;
            frame_start  <= load;
        end
    end

endmodule

// File: tb/tb_matrix_column_scanner.sv
// tb/tb_matrix_column_scanner.sv - scoreboard bench for matrix_column_scanner over three parameter sets
module tb_matrix_column_scanner;

    typedef struct packed {
        logic [6:0] rows;
        logic [4:0] cols;
        logic [2:0] idx;
        logic       fs;
    } exp_t;

    typedef exp_t [2:0] trio_t;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       enable;
    logic [6:0] col_in [5];

    logic [6:0] rows_o [3];
    logic [4:0] cols_o [3];
    logic [2:0] idx_o  [3];
    logic       fs_o   [3];

    int errors = 0;
    int checks = 0;
    int cycle_no = 0;

    // Instance parameters mirrored for the reference model.
    int cd_v  [3] = '{8, 4, 8};
    int bc_v  [3] = '{2, 0, 2};
    bit ral_v [3] = '{1'b0, 1'b0, 1'b1};
    bit cal_v [3] = '{1'b1, 1'b1, 1'b0};

    // Reference model: cycles elapsed since the scan started, plus the
    // snapshot of the inputs taken at each frame start.
    bit         run [3];
    int         t   [3];
    bit         fsm [3];
    logic [6:0] frm [3][5];

    trio_t sb[$];

    always #5 clock = ~clock;

    matrix_column_scanner #(.CLOCK_DIVIDER(8), .BLANK_CYCLES(2), .ROW_ACTIVE_LOW(1'b0), .COLUMN_ACTIVE_LOW(1'b1)) u_a (
        .clock(clock), .reset_n(reset_n), .enable(enable),
        .column_4(col_in[4]), .column_3(col_in[3]), .column_2(col_in[2]), .column_1(col_in[1]), .column_0(col_in[0]),
        .rows(rows_o[0]), .columns(cols_o[0]), .column_index(idx_o[0]), .frame_start(fs_o[0]));

    matrix_column_scanner #(.CLOCK_DIVIDER(4), .BLANK_CYCLES(0), .ROW_ACTIVE_LOW(1'b0), .COLUMN_ACTIVE_LOW(1'b1)) u_b (
        .clock(clock), .reset_n(reset_n), .enable(enable),
        .column_4(col_in[4]), .column_3(col_in[3]), .column_2(col_in[2]), .column_1(col_in[1]), .column_0(col_in[0]),
        .rows(rows_o[1]), .columns(cols_o[1]), .column_index(idx_o[1]), .frame_start(fs_o[1]));

    matrix_column_scanner #(.CLOCK_DIVIDER(8), .BLANK_CYCLES(2), .ROW_ACTIVE_LOW(1'b1), .COLUMN_ACTIVE_LOW(1'b0)) u_c (
        .clock(clock), .reset_n(reset_n), .enable(enable),
        .column_4(col_in[4]), .column_3(col_in[3]), .column_2(col_in[2]), .column_1(col_in[1]), .column_0(col_in[0]),
        .rows(rows_o[2]), .columns(cols_o[2]), .column_index(idx_o[2]), .frame_start(fs_o[2]));

    task automatic check(input string name, input int inst, input logic [6:0] act, input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst=%0d cycle=%0d: got %h required %h", name, inst, cycle_no, act, exp);
        end
    endtask

    function automatic exp_t expect_of(input int i);
        exp_t       e;
        int         col;
        bit         lit;
        logic [4:0] one;
        logic [4:0] raw_c;
        logic [6:0] raw_r;
        one   = 5'd1;
        col   = 4;
        lit   = 1'b0;
        raw_c = 5'h00;
        raw_r = 7'h00;
        if (run[i]) begin
            col = 4 - ((t[i] / cd_v[i]) % 5);
            lit = (t[i] % cd_v[i]) >= bc_v[i];
        end
        if (lit) begin
            raw_c = one << col;
            raw_r = frm[i][col];
        end
        e.rows = raw_r ^ (ral_v[i] ? 7'h7F : 7'h00);
        e.cols = raw_c ^ (cal_v[i] ? 5'h1F : 5'h00);
        e.idx  = 3'(col);
        e.fs   = run[i] && fsm[i];
        return e;
    endfunction

    task automatic capture(input int i);
        for (int c = 0; c < 5; c++) frm[i][c] = col_in[c];
    endtask

    task automatic model_edge();
        trio_t e;
        for (int i = 0; i < 3; i++) begin
            if (!reset_n || !enable) begin
                run[i] = 1'b0;
                fsm[i] = 1'b0;
            end else if (!run[i]) begin
                run[i] = 1'b1;
                t[i]   = 0;
                fsm[i] = 1'b1;
                capture(i);
            end else begin
                t[i]++;
                fsm[i] = (t[i] % (5 * cd_v[i])) == 0;
                if (fsm[i]) capture(i);
            end
            e[i] = expect_of(i);
        end
        sb.push_back(e);
        cycle_no++;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        model_edge();
        @(negedge clock);
    endtask

    task automatic check_idle_a(input string tag);
        check({tag, "_rows"}, 0, rows_o[0], 7'h00);
        check({tag, "_cols"}, 0, 7'(cols_o[0]), 7'h1F);
        check({tag, "_idx"},  0, 7'(idx_o[0]), 7'd4);
        check({tag, "_fs"},   0, 7'(fs_o[0]), 7'd0);
    endtask

    always @(negedge clock) begin
        trio_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            for (int i = 0; i < 3; i++) begin
                check("rows",         i, rows_o[i], e[i].rows);
                check("columns",      i, 7'(cols_o[i]), 7'(e[i].cols));
                check("column_index", i, 7'(idx_o[i]), 7'(e[i].idx));
                check("frame_start",  i, 7'(fs_o[i]), 7'(e[i].fs));
            end
        end
    end

    initial begin
        int n;
        for (int i = 0; i < 3; i++) begin
            run[i] = 1'b0;
            t[i]   = 0;
            fsm[i] = 1'b0;
            for (int c = 0; c < 5; c++) frm[i][c] = 7'h00;
        end
        reset_n   = 1'b0;
        enable    = 1'b1;
        col_in[4] = 7'b1111011;
        col_in[3] = 7'b1111101;
        col_in[2] = 7'b0000000;
        col_in[1] = 7'b1111101;
        col_in[0] = 7'b1111011;

        // Reset held with enable high and the clock running.
        repeat (4) step();
        check_idle_a("reset_hold");

        // Basic scan, then switch to the error pattern while column 2 is scanning.
        reset_n = 1'b1;
        n = 0;
        while (!(run[0] && t[0] == 18) && n < 100) begin
            step();
            n++;
        end
        check("reach_col2", 0, 7'(n), 7'(19));
        col_in[4] = 7'b1100011;
        col_in[3] = 7'b1011001;
        col_in[2] = 7'b1010101;
        col_in[1] = 7'b1001101;
        col_in[0] = 7'b1100011;
        repeat (70) step();

        // Drop enable during DRIVE tick 5 of column 3, then re-enable.
        enable = 1'b0;
        repeat (3) step();
        enable = 1'b1;
        n = 0;
        while (!(run[0] && t[0] == 13) && n < 100) begin
            step();
            n++;
        end
        check("reach_col3_tick5", 0, 7'(idx_o[0]), 7'd3);
        enable = 1'b0;
        step();
        check_idle_a("enable_drop");
        enable = 1'b1;
        step();
        check("restart_fs",   0, 7'(fs_o[0]), 7'd1);
        check("restart_cols", 0, 7'(cols_o[0]), 7'h1F);
        check("restart_idx",  0, 7'(idx_o[0]), 7'd4);
        repeat (20) step();

        // Randomised patterns and enable toggling.
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(7) == 0) col_in[$urandom_range(4)] = 7'($urandom);
            if (enable && $urandom_range(59) == 0) enable = 1'b0;
            else if (!enable && $urandom_range(3) == 0) enable = 1'b1;
            step();
        end

        // Asynchronous reset in the middle of a DRIVE phase.
        enable = 1'b1;
        n = 0;
        while (!(run[0] && (t[0] % 8) >= 2 && (t[0] % 8) <= 5) && n < 100) begin
            step();
            n++;
        end
        check("reach_drive", 0, 7'(cols_o[0] != 5'h1F), 7'd1);
        @(posedge clock);
        #1;
        model_edge();
        #1;
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            run[i] = 1'b0;
            fsm[i] = 1'b0;
        end
        sb.delete();
        begin
            trio_t e;
            for (int i = 0; i < 3; i++) e[i] = expect_of(i);
            sb.push_back(e);
        end
        #1;
        check_idle_a("async_reset");
        @(negedge clock);
        repeat (3) step();
        reset_n = 1'b1;
        repeat (50) step();
        #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
